// File: rtl/simple_cpu_sequencer_if.sv
// Host-side program/control bus of the simple_cpu program sequencer.
// The sequencer connects through the slave modport, the host through master.
interface simple_cpu_sequencer_if #(
  parameter int unsigned AW = 4
);
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [7:0]    prog_data;
  logic          start;
  logic          stop;
  logic [7:0]    instruction;
  logic          issue;
  logic [AW-1:0] pc;
  logic          busy;
  logic          done;

  modport master (
    output prog_we, prog_addr, prog_data, start, stop,
    input  instruction, issue, pc, busy, done
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, start, stop,
    output instruction, issue, pc, busy, done
  );
endinterface

// File: rtl/simple_cpu_sequencer.sv
// Program sequencer for simple_cpu: holds a DEPTH x 8 program and issues it
// one word at a time, each followed by GAP NOP cycles, until HLT or end of memory.
module simple_cpu_sequencer #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4,
  parameter int unsigned GAP   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  simple_cpu_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [3:0]    GAP_LAST = 4'(GAP - 1);
  localparam logic [AW-1:0] PC_LAST  = AW'(DEPTH - 1);
  localparam logic [3:0]    OP_HLT   = 4'hF;

  state_t        state, state_nx;
  logic [7:0]    mem [DEPTH];
  logic [7:0]    fetch_word;
  logic [AW-1:0] pc_q, pc_nx;
  logic [3:0]    cnt_q, cnt_nx;
  logic [7:0]    instr_q, instr_nx;
  logic          issue_q, issue_nx;
  logic          busy_q, done_q;
  logic          advance;
  logic          mem_open;

  assign fetch_word = mem[pc_q];
  assign mem_open   = (state == S_IDLE) || (state == S_DONE);

  // Program memory: host writes only while no run is in progress; not reset.
  always_ff @(posedge clk) begin
    if (bus.prog_we && mem_open) begin
      mem[bus.prog_addr] <= bus.prog_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      instr_q <= '0;
      issue_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nx;
      pc_q    <= pc_nx;
      cnt_q   <= cnt_nx;
      instr_q <= instr_nx;
      issue_q <= issue_nx;
      busy_q  <= (state_nx == S_FETCH) || (state_nx == S_ISSUE) ||
                 (state_nx == S_WAIT);
      done_q  <= (state_nx == S_DONE);
    end
  end

  always_comb begin
    state_nx = state;
    pc_nx    = pc_q;
    cnt_nx   = cnt_q;
    instr_nx = '0;
    issue_nx = 1'b0;
    advance  = 1'b0;

    case (state)
      S_IDLE: begin
        if (bus.start && !bus.stop) begin
          state_nx = S_FETCH;
          pc_nx    = '0;
        end
      end

      S_FETCH: begin
        if (bus.stop) begin
          state_nx = S_IDLE;
        end else if (fetch_word[7:4] == OP_HLT) begin
          state_nx = S_DONE;
        end else begin
          state_nx = S_ISSUE;
          instr_nx = fetch_word;
          issue_nx = 1'b1;
        end
      end

      S_ISSUE: begin
        if (bus.stop) begin
          state_nx = S_IDLE;
        end else if (GAP != 0) begin
          state_nx = S_WAIT;
          cnt_nx   = '0;
        end else begin
          advance = 1'b1;
        end
      end

      S_WAIT: begin
        if (bus.stop) begin
          state_nx = S_IDLE;
        end else if (cnt_q == GAP_LAST) begin
          advance = 1'b1;
        end else begin
          cnt_nx = cnt_q + 4'd1;
        end
      end

      S_DONE: begin
        if (bus.start && !bus.stop) begin
          state_nx = S_FETCH;
          pc_nx    = '0;
        end
      end

      default: state_nx = S_IDLE;
    endcase

    // Shared exit of ISSUE (GAP=0) and WAIT: stop at the last entry, no wrap.
    if (advance) begin
      if (pc_q == PC_LAST) begin
        state_nx = S_DONE;
      end else begin
        state_nx = S_FETCH;
        pc_nx    = pc_q + 1'b1;
      end
    end
  end

  assign bus.instruction = instr_q;
  assign bus.issue       = issue_q;
  assign bus.pc          = pc_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_simple_cpu_sequencer.sv
// Self-checking bench for simple_cpu_sequencer: a run-timeline reference model
// checked every cycle, directed scenarios with literal expectations, random traffic.
module tb_simple_cpu_sequencer;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int GAP   = 2;
  localparam int P     = GAP + 2;

  logic clk;
  logic reset;

  simple_cpu_sequencer_if #(.AW(AW)) bus ();

  simple_cpu_sequencer #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .GAP   (GAP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a run is described by the cycle count since start and the
  // index of the first HLT; outputs follow from the GAP+2 issue period.
  bit [7:0] m_mem [DEPTH];
  bit       m_run;
  int       m_rel, m_h, m_pc_idle;
  bit       model_ok;
  int       exp_instr, exp_issue, exp_pc, exp_busy, exp_done;

  function automatic int halt_index();
    for (int i = 0; i < DEPTH; i++)
      if (m_mem[i][7:4] == 4'hF) return i;
    return DEPTH;
  endfunction

  task automatic eval_model();
    int k, ph;
    exp_instr = 0; exp_issue = 0; exp_busy = 0; exp_done = 0;
    if (!m_run) begin
      exp_pc = m_pc_idle;
    end else begin
      k  = (m_rel - 1) / P;
      ph = (m_rel - 1) % P;
      if (k < m_h) begin
        exp_busy  = 1;
        exp_pc    = k;
        exp_issue = (ph == 1) ? 1 : 0;
        exp_instr = exp_issue ? int'(m_mem[k]) : 0;
      end else if (k == m_h && ph == 0 && m_h < DEPTH) begin
        exp_busy = 1;
        exp_pc   = m_h;
      end else begin
        exp_done = 1;
        exp_pc   = (m_h < DEPTH) ? m_h : DEPTH - 1;
      end
    end
  endtask

  initial begin
    m_run = 0; m_rel = 0; m_h = DEPTH; m_pc_idle = 0; model_ok = 0;
    exp_instr = 0; exp_issue = 0; exp_pc = 0; exp_busy = 0; exp_done = 0;
  end

  always @(posedge clk) begin
    if (bus.prog_we && exp_busy == 0) m_mem[bus.prog_addr] = bus.prog_data;
    if (reset) begin
      m_run     = 0;
      m_pc_idle = 0;
    end else if (exp_busy != 0) begin
      if (bus.stop) begin
        m_run     = 0;
        m_pc_idle = exp_pc;
      end else begin
        m_rel++;
      end
    end else if (bus.start && !bus.stop) begin
      m_run = 1;
      m_rel = 1;
      m_h   = halt_index();
    end
    eval_model();
    model_ok = 1;
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("instruction", int'(bus.instruction), exp_instr);
      chk("issue",       int'(bus.issue),       exp_issue);
      chk("pc",          int'(bus.pc),          exp_pc);
      chk("busy",        int'(bus.busy),        exp_busy);
      chk("done",        int'(bus.done),        exp_done);
    end
  end

  // Per-cycle record of a directed run; index = cycle number after start edge 0.
  int rec_instr [128];
  int rec_issue [128];
  int rec_pc    [128];
  int rec_busy  [128];
  int rec_done  [128];

  task automatic load(input int addr, input int data);
    @(negedge clk);
    bus.prog_we   = 1'b1;
    bus.prog_addr = AW'(addr);
    bus.prog_data = 8'(data);
    @(negedge clk);
    bus.prog_we   = 1'b0;
  endtask

  task automatic run(input int n, input int stop_e, input int cmd_e, input int rst_e);
    @(negedge clk);
    bus.start = 1'b1;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      rec_instr[c]  = int'(bus.instruction);
      rec_issue[c]  = int'(bus.issue);
      rec_pc[c]     = int'(bus.pc);
      rec_busy[c]   = int'(bus.busy);
      rec_done[c]   = int'(bus.done);
      bus.start     = (c == cmd_e);
      bus.stop      = (c == stop_e);
      reset         = (c == rst_e);
      bus.prog_we   = (c == cmd_e);
      bus.prog_addr = AW'(1);
      bus.prog_data = 8'hFF;
    end
    @(negedge clk);
    bus.start = 1'b0; bus.stop = 1'b0; reset = 1'b0; bus.prog_we = 1'b0;
  endtask

  function automatic int issue_count(input int n);
    int cnt = 0;
    for (int c = 1; c <= n; c++) cnt += rec_issue[c];
    return cnt;
  endfunction

  function automatic int last_issue(input int n);
    int last = -1;
    for (int c = 1; c <= n; c++) if (rec_issue[c] != 0) last = c;
    return last;
  endfunction

  task automatic check_normal(input string tag);
    chk({tag, "_c2_instr"}, rec_instr[2], 8'h15);
    chk({tag, "_c2_issue"}, rec_issue[2], 1);
    chk({tag, "_c6_instr"}, rec_instr[6], 8'h23);
    chk({tag, "_c10_instr"}, rec_instr[10], 8'h32);
    chk({tag, "_c3_instr"}, rec_instr[3], 0);
    chk({tag, "_issues"}, issue_count(16), 3);
    chk({tag, "_c13_done"}, rec_done[13], 0);
    chk({tag, "_c14_done"}, rec_done[14], 1);
    chk({tag, "_c14_pc"}, rec_pc[14], 3);
  endtask

  initial begin
    int r;
    reset = 1'b1;
    bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = '0;
    bus.start = 1'b0; bus.stop = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_pc", int'(bus.pc), 0);

    // End of memory without HLT
    for (int a = 0; a < DEPTH; a++) load(a, 8'h21);
    run(70, -1, -1, -1);
    chk("eom_issues", issue_count(70), 16);
    chk("eom_last_issue", last_issue(70), 62);
    chk("eom_c64_done", rec_done[64], 0);
    chk("eom_c65_done", rec_done[65], 1);
    chk("eom_c65_pc", rec_pc[65], 15);
    chk("eom_c70_pc", rec_pc[70], 15);

    // Normal run
    load(0, 8'h15); load(1, 8'h23); load(2, 8'h32); load(3, 8'hF0);
    run(16, -1, -1, -1);
    check_normal("norm");

    // Immediate halt
    load(0, 8'hF0);
    run(5, -1, -1, -1);
    chk("halt_c1_busy", rec_busy[1], 1);
    chk("halt_c2_busy", rec_busy[2], 0);
    chk("halt_c2_done", rec_done[2], 1);
    chk("halt_c2_pc", rec_pc[2], 0);
    chk("halt_issues", issue_count(5), 0);
    load(0, 8'h15);

    // Stop at edge 7, then restart
    run(12, 7, -1, -1);
    chk("stop_c8_busy", rec_busy[8], 0);
    chk("stop_c8_done", rec_done[8], 0);
    chk("stop_c8_pc", rec_pc[8], 1);
    chk("stop_c10_issue", rec_issue[10], 0);
    chk("stop_issues", issue_count(12), 2);
    run(16, -1, -1, -1);
    check_normal("restart");

    // Write + start during a run are ignored
    run(16, -1, 3, -1);
    check_normal("ignored");
    run(16, -1, -1, -1);
    check_normal("ignored_reread");

    // Reset at edge 5, then replay
    run(10, -1, -1, 5);
    chk("rst_c6_busy", rec_busy[6], 0);
    chk("rst_c6_issue", rec_issue[6], 0);
    chk("rst_c6_pc", rec_pc[6], 0);
    chk("rst_c6_done", rec_done[6], 0);
    chk("rst_c6_instr", rec_instr[6], 0);
    chk("rst_issues", issue_count(10), 1);
    run(16, -1, -1, -1);
    check_normal("post_reset");

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      r = int'($urandom_range(0, 199));
      bus.start     = (r < 12);
      bus.stop      = (r >= 12 && r < 16);
      reset         = (r == 199);
      bus.prog_we   = ($urandom_range(0, 4) == 0);
      bus.prog_addr = AW'($urandom_range(0, DEPTH - 1));
      bus.prog_data = 8'($urandom_range(0, 255));
    end
    @(negedge clk);
    bus.start = 1'b0; bus.stop = 1'b0; reset = 1'b0; bus.prog_we = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
